// File: rtl/gen_pipe_elastic_if.sv
// Valid/ready/data handshake bundle for gen_pipe_elastic.
// The master drives valid and data; the slave drives ready.
interface gen_pipe_elastic_if #(
  parameter int unsigned DW = 32
) ();
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gen_pipe_elastic.sv
// DEPTH-stage elastic pipeline with bubble collapsing, hold, flush and a default output value.
// Defining GEN_PIPE_ELASTIC_SKID_EN adds a one-entry skid register that registers in_ready upstream.
module gen_pipe_elastic #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 2)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               hold_en_i,
  input  logic               flush_i,
  input  logic [DW-1:0]      def_val_i,
  gen_pipe_elastic_if.slave  in_if,
  gen_pipe_elastic_if.master out_if,
  output logic [CW-1:0]      occupancy_o
);

  logic             run;
  logic             rdy_out;
  logic [DEPTH-1:0] rdy_st;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DW-1:0]    data_q [DEPTH];
  logic [DW-1:0]    data_d [DEPTH];
  logic [CW-1:0]    occ_q, occ_d;
  logic             in_xfer, out_xfer;
  logic             src_vld;
  logic [DW-1:0]    src_data;

  assign run     = ~hold_en_i & ~flush_i;
  assign rdy_out = out_if.ready & run;

  // Stage i can load when it or any stage downstream of it is empty, or the output drains.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      rdy_st[i] = rdy_out;
      for (int j = i; j < int'(DEPTH); j++) begin
        if (!vld_q[j]) rdy_st[i] = 1'b1;
      end
    end
  end

`ifdef GEN_PIPE_ELASTIC_SKID_EN
  logic          skid_vld_q, skid_vld_d;
  logic [DW-1:0] skid_data_q, skid_data_d;

  assign in_if.ready = ~skid_vld_q & run;
  assign in_xfer     = in_if.valid & in_if.ready;
  assign src_vld     = skid_vld_q | in_xfer;
  assign src_data    = skid_vld_q ? skid_data_q : in_if.data;

  always_comb begin
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    if (flush_i) begin
      skid_vld_d = 1'b0;
    end else if (!hold_en_i) begin
      if (skid_vld_q) begin
        if (rdy_st[0]) skid_vld_d = 1'b0;
      end else if (in_xfer && !rdy_st[0]) begin
        skid_vld_d  = 1'b1;
        skid_data_d = in_if.data;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
    end else begin
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
    end
  end
`else
  assign in_if.ready = rdy_st[0] & run;
  assign in_xfer     = in_if.valid & in_if.ready;
  assign src_vld     = in_xfer;
  assign src_data    = in_if.data;
`endif

  assign out_xfer = vld_q[DEPTH-1] & rdy_out;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (flush_i) begin
      vld_d = '0;
    end else if (run) begin
      if (rdy_st[0]) begin
        vld_d[0] = src_vld;
        if (src_vld) data_d[0] = src_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (rdy_st[i]) begin
          vld_d[i] = vld_q[i-1];
          if (vld_q[i-1]) data_d[i] = data_q[i-1];
        end
      end
    end
  end

  always_comb begin
    if (flush_i) occ_d = '0;
    else         occ_d = occ_q + CW'(in_xfer) - CW'(out_xfer);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      data_q <= '{default: '0};
      occ_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      occ_q  <= occ_d;
    end
  end

  assign out_if.valid = vld_q[DEPTH-1];
  assign out_if.data  = vld_q[DEPTH-1] ? data_q[DEPTH-1] : def_val_i;
  assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_gen_pipe_elastic.sv
// Randomised and directed bench for gen_pipe_elastic against a queue-of-entries reference model.
// Each entry carries its position (-1 = skid); entries advance oldest-first into free slots.
module tb_gen_pipe_elastic;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CW    = $clog2(DEPTH + 2);

  typedef struct {
    logic [DW-1:0] d;
    int            pos;
  } ent_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          hold_en;
  logic          flush;
  logic [DW-1:0] def_val;
  logic [CW-1:0] occupancy;

  gen_pipe_elastic_if #(.DW(DW)) in_if ();
  gen_pipe_elastic_if #(.DW(DW)) out_if ();

  gen_pipe_elastic #(
    .DW   (DW),
    .DEPTH(DEPTH)
  ) u_dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .hold_en_i  (hold_en),
    .flush_i    (flush),
    .def_val_i  (def_val),
    .in_if      (in_if),
    .out_if     (out_if),
    .occupancy_o(occupancy)
  );

  always #5 clk_i = ~clk_i;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   peak    = 0;
  ent_t mq[$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: starts and ends just after a negedge.
  task automatic tick(input bit iv, input logic [DW-1:0] id, input bit ordy, input bit hold,
                      input bit fl);
    ent_t          nq[$];
    ent_t          e;
    int            ahead;
    bit            eff_ordy, exp_rdy, to_stage0, exp_ov;
    logic [DW-1:0] exp_od;
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    hold_en      = hold;
    flush        = fl;
    #1;
    eff_ordy = ordy && !hold && !fl;
    ahead    = int'(DEPTH);
    foreach (mq[k]) begin
      e = mq[k];
      if (k == 0 && e.pos == int'(DEPTH) - 1 && eff_ordy) continue;
      if (e.pos + 1 < ahead) e.pos = e.pos + 1;
      ahead = e.pos;
      nq.push_back(e);
    end
    to_stage0 = (ahead > 0);
`ifdef GEN_PIPE_ELASTIC_SKID_EN
    exp_rdy = !hold && !fl && !(mq.size() > 0 && mq[$].pos == -1);
`else
    exp_rdy = !hold && !fl && to_stage0;
`endif
    exp_ov = (mq.size() > 0) && (mq[0].pos == int'(DEPTH) - 1);
    exp_od = exp_ov ? mq[0].d : def_val;
    check("in_ready", DW'(in_if.ready), DW'(exp_rdy));
    check("out_valid", DW'(out_if.valid), DW'(exp_ov));
    check("out_data", out_if.data, exp_od);
    check("occupancy", DW'(occupancy), DW'(mq.size()));
    @(posedge clk_i);
    if (fl) begin
      mq.delete();
    end else if (!hold) begin
      mq = nq;
      if (iv && exp_rdy) begin
        e.d   = id;
        e.pos = to_stage0 ? 0 : -1;
        mq.push_back(e);
      end
    end
    if (mq.size() > peak) peak = mq.size();
    @(negedge clk_i);
  endtask

  initial begin
    rst_ni       = 1'b0;
    hold_en      = 1'b0;
    flush        = 1'b0;
    def_val      = 32'hCAFE_0000;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b1;
    #2;
    check("rst_out_valid", DW'(out_if.valid), 32'd0);
    check("rst_out_data", out_if.data, 32'hCAFE_0000);
    check("rst_occupancy", DW'(occupancy), 32'd0);
    check("rst_in_ready", DW'(in_if.ready), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Streaming, latency and throughput.
    tick(1, 32'h11, 1, 0, 0);
    tick(1, 32'h22, 1, 0, 0);
    tick(1, 32'h33, 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 32'h0, 1, 0, 0);
    check("stream_peak", DW'(peak), 32'd3);

    // Fill with backpressure, then one-cycle drain with simultaneous refill.
    for (int i = 0; i < 3; i++) tick(1, 32'hA0 + DW'(i), 0, 0, 0);
    tick(1, 32'hA3, 0, 0, 0);
    tick(1, 32'hA3, 0, 0, 0);
    tick(1, 32'hA3, 1, 0, 0);
    tick(0, 32'h0, 0, 0, 0);
    check("full_occupancy", DW'(occupancy), DW'(mq.size()));
    tick(0, 32'h0, 0, 0, 1);

    // Bubble collapse.
    tick(1, 32'hAAAA, 0, 0, 0);
    tick(0, 32'h0, 0, 0, 0);
    tick(1, 32'hBBBB, 0, 0, 0);
    tick(0, 32'h0, 0, 0, 0);
    check("bubble_occupancy", DW'(occupancy), 32'd2);
    tick(0, 32'h0, 0, 0, 1);

    // Default value on empty output.
    def_val = 32'hDEAD_BEEF;
    tick(0, 32'h0, 1, 0, 0);
    tick(1, 32'h5, 1, 0, 0);
    for (int i = 0; i < 5; i++) tick(0, 32'h0, 1, 0, 0);

    // Flush beats hold and refuses the offered input.
    tick(1, 32'h77, 0, 0, 0);
    tick(1, 32'h78, 0, 0, 0);
    tick(1, 32'h79, 1, 1, 1);
    check("flush_occupancy", DW'(occupancy), 32'd0);
    tick(0, 32'h0, 1, 0, 0);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 4; i++) tick(1, 32'hC0 + DW'(i), 0, 0, 0);
    in_if.valid = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_out_valid", DW'(out_if.valid), 32'd0);
    check("arst_occupancy", DW'(occupancy), 32'd0);
    check("arst_out_data", out_if.data, def_val);
    mq.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 8; i++) tick(1, 32'hD0 + DW'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 32'h0, 1, 0, 0);

    // Random phases with varying backpressure.
    for (int ph = 0; ph < 8; ph++) begin
      int unsigned rdy_pct;
      rdy_pct = (ph % 4 == 0) ? 10 : (ph % 4 == 1) ? 50 : (ph % 4 == 2) ? 90 : 100;
      for (int i = 0; i < 80; i++) begin
        if ($urandom_range(0, 19) == 0) def_val = $urandom;
        tick($urandom_range(0, 3) != 0, $urandom, $urandom_range(1, 100) <= rdy_pct,
             $urandom_range(0, 15) == 0, $urandom_range(0, 39) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
